// File: rtl/conv213_pkg.sv
// Shared definitions for the rate-1/2, K=3 convolutional encoder (and its decoder).
// Contents: generator polynomials G0/G1 (applied to {b, s[1], s[0]}), symbol width,
// and the encoder FSM state type.
package conv213_pkg;

  localparam logic [2:0]  G0    = 3'b111;  // octal 7
  localparam logic [2:0]  G1    = 3'b101;  // octal 5
  localparam int unsigned SYM_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StTail
  } fsm_e;

endpackage

// File: rtl/conv213_branch.sv
// Combinational trellis branch of the K=3 code.
// Ports:
//   s_i      current 2-bit state; [1] newest bit, [0] the one before it
//   b_i      input bit
//   sym_o    encoded symbol: [1] = g0 output, [0] = g1 output
//   s_next_o next state {b, s[1]}
module conv213_branch
  import conv213_pkg::*;
(
  input  logic [1:0]       s_i,
  input  logic             b_i,
  output logic [SYM_W-1:0] sym_o,
  output logic [1:0]       s_next_o
);

  logic [2:0] taps;

  always_comb begin
    taps     = {b_i, s_i};
    sym_o[1] = ^(taps & G0);
    sym_o[0] = ^(taps & G1);
    s_next_o = {b_i, s_i[1]};
  end

endmodule

// File: rtl/conv_encoder_213.sv
// Framed rate-1/2, K=3 convolutional encoder (g0 = 7, g1 = 5 octal) with valid/ready
// handshakes on both sides and a registered output stage (1-cycle latency).
// Build option: define CONV_ENC_TAIL_EN to append two zero tail bits per frame
// (FRAME_LEN + 2 symbols); otherwise the state is cleared after the last data bit and
// a frame is FRAME_LEN symbols.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_bit       input bit stream; in_ready accepts
//   out_valid/out_sym     encoded symbol; out_ready accepts
//   out_first/out_last    frame markers qualifying out_sym
module conv_encoder_213
  import conv213_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic [SYM_W-1:0] out_sym,
  output logic             out_first,
  output logic             out_last,
  input  logic             out_ready
);

  localparam logic [7:0] LastCnt = 8'(FRAME_LEN - 1);

  fsm_e             fsm_q, fsm_d;
  logic [1:0]       s_q, s_d;
  logic [7:0]       count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [SYM_W-1:0] out_sym_q, out_sym_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;

  logic             load_ok, accept, last_bit, enc_b;
  logic [SYM_W-1:0] br_sym;
  logic [1:0]       br_s_next;

  // A new symbol may be loaded when the output register is empty or being drained now.
  assign load_ok  = !out_valid_q || out_ready;
  assign in_ready = (fsm_q == StData) && load_ok;
  assign accept   = in_valid && in_ready;
  assign last_bit = (count_q == LastCnt);

`ifdef CONV_ENC_TAIL_EN
  logic tail_idx_q, tail_idx_d;
  logic tail_load;
  assign tail_load = (fsm_q == StTail) && load_ok;
  assign enc_b     = (fsm_q == StTail) ? 1'b0 : in_bit;
`else
  assign enc_b     = in_bit;
`endif

  conv213_branch u_branch (
    .s_i      (s_q),
    .b_i      (enc_b),
    .sym_o    (br_sym),
    .s_next_o (br_s_next)
  );

  always_comb begin
    fsm_d       = fsm_q;
    s_d         = s_q;
    count_d     = count_q;
    out_valid_d = out_valid_q && !out_ready;
    out_sym_d   = out_sym_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
`ifdef CONV_ENC_TAIL_EN
    tail_idx_d  = tail_idx_q;
`endif
    unique case (fsm_q)
      StIdle: fsm_d = StData;
      StData: begin
        if (accept) begin
          s_d         = br_s_next;
          count_d     = last_bit ? 8'd0 : 8'(count_q + 8'd1);
          out_valid_d = 1'b1;
          out_sym_d   = br_sym;
          out_first_d = (count_q == 8'd0);
          out_last_d  = 1'b0;
          if (last_bit) begin
`ifdef CONV_ENC_TAIL_EN
            fsm_d      = StTail;
            tail_idx_d = 1'b0;
`else
            // No tail: force the trellis back to state 0 for the next frame.
            s_d        = 2'b00;
            out_last_d = 1'b1;
`endif
          end
        end
      end
`ifdef CONV_ENC_TAIL_EN
      StTail: begin
        if (tail_load) begin
          s_d         = br_s_next;
          out_valid_d = 1'b1;
          out_sym_d   = br_sym;
          out_first_d = 1'b0;
          out_last_d  = tail_idx_q;
          tail_idx_d  = 1'b1;
          if (tail_idx_q) fsm_d = StData;
        end
      end
`endif
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= StIdle;
      s_q         <= 2'b00;
      count_q     <= 8'd0;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      s_q         <= s_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef CONV_ENC_TAIL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tail_idx_q <= 1'b0;
    else     tail_idx_q <= tail_idx_d;
  end
`endif

  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;

endmodule

// File: doc/conv_encoder_213.md
CONV_ENCODER_213 -- requirements
Module: conv_encoder_213

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 11, meaning data bits per frame (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  in_bit is valid this cycle.
REQ-005 SHALL have port in_bit  input  1  data bit to encode.
REQ-006 SHALL have port in_ready  output  1  encoder accepts in_bit this cycle.
REQ-007 SHALL have port out_valid  output  1  out_sym holds a valid symbol.
REQ-008 SHALL have port out_sym  output  2  encoded symbol: [1] = g0 output, [0] = g1 output.
REQ-009 SHALL have port out_first  output  1  out_sym is the first symbol of a frame.
REQ-010 SHALL have port out_last  output  1  out_sym is the last symbol of a frame.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_sym this cycle.

Function
REQ-012 SHALL implement the rate-1/2, K=3 code: g0 = 111 (octal 7), g1 = 101 (octal 5).
REQ-013 SHALL hold a 2-bit state s; s[1] is the most recent input bit and s[0] the one before it.
REQ-014 SHALL compute g0 = b ^ s[1] ^ s[0] and g1 = b ^ s[0] for input b, then set next s = {b, s[1]}; this matches decoder transitions 0/1 -> 0/2 and 2/3 -> 1/3.
REQ-015 SHALL transfer an input only when in_valid and in_ready are both high, and a symbol only when out_valid and out_ready are both high.
REQ-016 SHALL drive in_ready = (fsm == DATA) and (out_valid == 0 or out_ready == 1); it is combinational from registered state and out_ready.
REQ-017 SHALL register out_sym, out_valid, out_first and out_last, giving 1-cycle latency from input accept to out_valid.
REQ-018 SHALL hold out_sym, out_first and out_last stable while out_valid is high and out_ready is low.
REQ-019 SHALL implement FSM states IDLE, DATA and TAIL, with these transitions:
- IDLE -> DATA after reset release (one cycle).
- DATA -> TAIL on accept of data bit FRAME_LEN.
- TAIL -> DATA after both tail symbols are loaded.
REQ-020 SHALL, in TAIL, inject two zero bits into the encoder with no input consumed; each tail symbol is loaded when out_valid == 0 or out_ready == 1.
REQ-021 SHALL count data bits with an 8-bit counter: cleared at frame start, incremented per accept, never wrapping past FRAME_LEN.
REQ-022 SHALL assert out_first on the symbol for data bit 1, and out_last on the second tail symbol.
REQ-023 SHALL reach s == 00 at every frame boundary, so the decoder always starts in state 0.
REQ-024 SHALL, with FRAME_LEN = 1, assert out_first and out_last on different symbols (3 symbols per frame).
REQ-025 SHALL, when an output accept and a new load fall in the same cycle, perform the load with no bubble.

Reset
REQ-026 SHALL, on rst assertion, immediately force fsm = IDLE, s = 00, count = 0, out_valid = 0, out_sym = 00, out_first = 0 and out_last = 0.
REQ-027 SHALL hold in_ready = 0 while rst is high and for the IDLE cycle after rst is released.
REQ-028 SHALL discard any partial frame when reset occurs mid-frame; no tail is emitted for it.

Configuration
REQ-029 SHALL gate tail insertion with the macro CONV_ENC_TAIL_EN:
- Defined: behaviour is as in REQ-019..REQ-023; the frame is FRAME_LEN + 2 symbols.
- Undefined: there is no TAIL state; DATA stays in DATA and clears s to 00 after data bit FRAME_LEN; out_last goes on that bit's symbol; the frame is FRAME_LEN symbols.

Structure
REQ-030 SHALL place constants G0 = 3'b111, G1 = 3'b101, SYM_W = 2 and the FSM state enum type in shared package conv213_pkg, which the decoder also uses.
REQ-031 SHALL implement REQ-014 in a combinational sub-module conv213_branch (inputs s and b; outputs sym and next s); the decoder may reuse it for its branch labels.

Verification
REQ-032 SHALL cover: FRAME_LEN=4, out_ready=1, bits 1,0,1,1 -> symbols 11,10,00,01,01,11; out_first on the 1st, out_last on the 6th; s = 00 after.
REQ-033 SHALL cover: same stimulus with out_ready low for 3 cycles after the 2nd symbol -> out_sym stays 10 with out_valid high, in_ready = 0, and the sequence resumes unchanged.
REQ-034 SHALL cover: two back-to-back frames (bits 1,1,1,1 then 0,0,0,1) -> frame 2 starts from s = 00, and its first three symbols are 00,00,00 then 11.
REQ-035 SHALL cover: rst pulsed after 2 data bits -> next cycle out_valid = 0 and s = 00; after release, the next frame's first symbol has out_first = 1.
REQ-036 SHALL cover: CONV_ENC_TAIL_EN undefined with FRAME_LEN=4 and bits 1,0,1,1 -> symbols 11,10,00,01 only, with out_last on 01.
REQ-037 SHALL cover: random bits, random out_ready and FRAME_LEN=11, looped into the Viterbi decoder -> decoded bits equal the inputs in every frame.
